// File: rtl/bsg_cache_buffer_queue_n.sv
// N-entry in-order buffer queue for the cache write/evict path.
// Entry 0 is always the oldest; an empty queue can pass data_i straight to data_o.
module bsg_cache_buffer_queue_n #(
    parameter int width_p  = 16,
    parameter int els_p    = 4,
    parameter bit bypass_p = 1'b1,
    localparam int count_width_lp = $clog2(els_p+1)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       yumi_i,
    output logic [els_p-1:0]           els_valid_o,
    output logic [els_p*width_p-1:0]   els_snoop_o,
    output logic [count_width_lp-1:0]  count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    // Handshake: the producer offers data_i with v_i=1 and must see full_o=0
    // unless it pops in the same cycle; the consumer asserts yumi_i only
    // while v_o=1 and thereby takes data_o in that cycle.

    logic [width_p-1:0]        data_q  [els_p];
    logic [width_p-1:0]        data_d  [els_p];
    logic [width_p-1:0]        shifted [els_p];
    logic [count_width_lp-1:0] count_q, count_d;
    logic                      empty, bypass, push, pop;

    assign empty  = (count_q == '0);
    // A bypassed beat never touches storage, so it is neither a push nor a pop.
    assign bypass = bypass_p && empty && v_i && yumi_i;
    assign push   = !reset_i && v_i && !bypass;
    assign pop    = !reset_i && yumi_i && !empty;

    always_comb begin
        for (int i = 0; i < els_p - 1; i++) begin
            shifted[i] = data_q[i+1];
        end
        shifted[els_p-1] = data_q[els_p-1];
    end

    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            data_d[i] = data_q[i];
            if (pop) begin
                data_d[i] = shifted[i];
                if (push && (i == int'(count_q) - 1)) begin
                    data_d[i] = data_i;
                end
            end else if (push && (i == int'(count_q))) begin
                data_d[i] = data_i;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + count_width_lp'(1);
        end else if (pop && !push) begin
            count_d = count_q - count_width_lp'(1);
        end
    end

    // Entry data carries no reset; validity comes from count_q alone.
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign v_o     = !empty || (bypass_p && v_i);
    assign data_o  = empty ? data_i : data_q[0];
    assign count_o = count_q;
    assign empty_o = empty;
    assign full_o  = (count_q == count_width_lp'(els_p));

    always_comb begin
        for (int i = 0; i < els_p; i++) begin
            els_valid_o[i]                   = (int'(count_q) > i);
            els_snoop_o[i*width_p +: width_p] = data_q[i];
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(v_i && full_o && !yumi_i));
            assert (!(yumi_i && !v_o));
            assert (bypass_p || !(yumi_i && empty));
        end
    end
`endif

endmodule

// File: tb/tb_bsg_cache_buffer_queue_n.sv
// Bench for bsg_cache_buffer_queue_n: a bypassing 4-entry queue and a
// non-bypassing 2-entry queue, each checked against its own expected queue.
module tb_bsg_cache_buffer_queue_n;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          v_i = 1'b0, yumi_i = 1'b0;
    logic [W-1:0]  data_i = '0;
    logic          v_o, empty_o, full_o;
    logic [W-1:0]  data_o;
    logic [3:0]    els_valid_o;
    logic [4*W-1:0] snoop_o;
    logic [2:0]    count_o;

    logic          v2_i = 1'b0, yumi2_i = 1'b0;
    logic [W-1:0]  data2_i = '0;
    logic          v2_o, empty2_o, full2_o;
    logic [W-1:0]  data2_o;
    logic [1:0]    els_valid2_o;
    logic [2*W-1:0] snoop2_o;
    logic [1:0]    count2_o;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp2_q[$];

    bsg_cache_buffer_queue_n #(.width_p(W), .els_p(4), .bypass_p(1'b1)) dut (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data_i),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
        .els_valid_o(els_valid_o), .els_snoop_o(snoop_o), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o)
    );

    bsg_cache_buffer_queue_n #(.width_p(W), .els_p(2), .bypass_p(1'b0)) dut2 (
        .clk_i(clk), .reset_i(rst), .v_i(v2_i), .data_i(data2_i),
        .v_o(v2_o), .data_o(data2_o), .yumi_i(yumi2_i),
        .els_valid_o(els_valid2_o), .els_snoop_o(snoop2_o), .count_o(count2_o),
        .empty_o(empty2_o), .full_o(full2_o)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output beat must match the oldest expected value.
    always @(negedge clk) begin
        if (!rst && v_o && yumi_i) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop_data: got %0h expected nothing", data_o);
            end else begin
                chk("pop_data", 64'(data_o), 64'(exp_q.pop_front()));
            end
        end
        if (!rst && v2_o && yumi2_i) begin
            if (exp2_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL pop2_data: got %0h expected nothing", data2_o);
            end else begin
                chk("pop2_data", 64'(data2_o), 64'(exp2_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic v, input logic [W-1:0] d, input logic y);
        v_i = v; data_i = d; yumi_i = y;
        if (v) exp_q.push_back(d);
        @(posedge clk); #1;
        v_i = 1'b0; yumi_i = 1'b0;
    endtask

    task automatic drive2(input logic v, input logic [W-1:0] d, input logic y);
        v2_i = v; data2_i = d; yumi2_i = y;
        if (v) exp2_q.push_back(d);
        @(posedge clk); #1;
        v2_i = 1'b0; yumi2_i = 1'b0;
    endtask

    initial begin
        // Reset state and reset-time output rule.
        #2;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_empty", 64'(empty_o), 64'd1);
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_valid", 64'(els_valid_o), 64'd0);
        v_i = 1'b1; v2_i = 1'b1;
        #1;
        chk("rst_v_o_bypass", 64'(v_o), 64'd1);
        chk("rst_v2_o_nobypass", 64'(v2_o), 64'd0);
        v_i = 1'b0; v2_i = 1'b0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Bypass when empty.
        v_i = 1'b1; data_i = 16'hA5A5; yumi_i = 1'b1;
        exp_q.push_back(16'hA5A5);
        #1;
        chk("byp_v_o", 64'(v_o), 64'd1);
        chk("byp_data_o", 64'(data_o), 64'hA5A5);
        @(posedge clk); #1;
        v_i = 1'b0; yumi_i = 1'b0;
        chk("byp_count", 64'(count_o), 64'd0);
        chk("byp_empty", 64'(empty_o), 64'd1);

        // Fill then drain.
        for (int k = 1; k <= 4; k++) drive(1'b1, 16'(k), 1'b0);
        chk("fill_full", 64'(full_o), 64'd1);
        chk("fill_count", 64'(count_o), 64'd4);
        chk("fill_valid", 64'(els_valid_o), 64'hF);
        chk("fill_snoop", 64'(snoop_o), 64'h0004_0003_0002_0001);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1);
        chk("drain_empty", 64'(empty_o), 64'd1);
        chk("drain_v_o", 64'(v_o), 64'd0);

        // Simultaneous push/pop while full.
        for (int k = 1; k <= 4; k++) drive(1'b1, 16'(k), 1'b0);
        drive(1'b1, 16'd5, 1'b1);
        chk("fullpp_snoop", 64'(snoop_o), 64'h0005_0004_0003_0002);
        chk("fullpp_count", 64'(count_o), 64'd4);
        chk("fullpp_full", 64'(full_o), 64'd1);
        for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1);
        chk("fullpp_empty", 64'(empty_o), 64'd1);

        // Mid-occupancy push/pop.
        drive(1'b1, 16'd7, 1'b0);
        drive(1'b1, 16'd8, 1'b0);
        drive(1'b1, 16'd9, 1'b1);
        chk("mid_count", 64'(count_o), 64'd2);
        chk("mid_snoop", 64'(snoop_o[2*W-1:0]), 64'h0009_0008);
        chk("mid_valid", 64'(els_valid_o), 64'b0011);
        drive(1'b0, '0, 1'b1);
        chk("mid_head", 64'(data_o), 64'd9);
        drive(1'b0, '0, 1'b1);

        // Asynchronous reset between edges discards contents at once.
        drive(1'b1, 16'd11, 1'b0);
        drive(1'b1, 16'd12, 1'b0);
        drive(1'b1, 16'd13, 1'b0);
        chk("pre_rst_count", 64'(count_o), 64'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_valid", 64'(els_valid_o), 64'd0);
        chk("arst_empty", 64'(empty_o), 64'd1);
        exp_q.delete();
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        drive(1'b1, 16'h1234, 1'b0);
        chk("post_rst_count", 64'(count_o), 64'd1);
        drive(1'b0, '0, 1'b1);

        // Non-bypassing 2-entry queue: one cycle of latency.
        v2_i = 1'b1; data2_i = 16'hBEEF; yumi2_i = 1'b0;
        exp2_q.push_back(16'hBEEF);
        #1;
        chk("nb_v_o_same", 64'(v2_o), 64'd0);
        @(posedge clk); #1;
        v2_i = 1'b0;
        chk("nb_v_o_next", 64'(v2_o), 64'd1);
        chk("nb_data_next", 64'(data2_o), 64'hBEEF);
        drive2(1'b1, 16'hCAFE, 1'b0);
        chk("nb_full", 64'(full2_o), 64'd1);
        chk("nb_count", 64'(count2_o), 64'd2);
        drive2(1'b1, 16'hF00D, 1'b1);
        chk("nb_pp_snoop", 64'(snoop2_o), 64'hF00D_CAFE);
        chk("nb_pp_valid", 64'(els_valid2_o), 64'b11);
        drive2(1'b0, '0, 1'b1);
        drive2(1'b0, '0, 1'b1);
        chk("nb_empty", 64'(empty2_o), 64'd1);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        chk("exp2_q_drained", 64'(exp2_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
